uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter letting NUM_REQ byte streams share one UART TX port, granted per packet.
// Data path is combinational from the owner; GAP_CYCLES idle clocks follow each packet; stalls abort after TIMEOUT_CYCLES.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                 clk_100MHz,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   src_valid,
   input  logic [8*NUM_REQ-1:0] src_data,
   input  logic [NUM_REQ-1:0]   src_last,
   output logic [NUM_REQ-1:0]   src_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 timeout_err
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
   localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_MAX   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IW-1:0]      r_gidx;
   logic [IW-1:0]      r_ptr;
   logic [IW-1:0]      w_win_idx;
   logic               w_win_vld;
   logic [NUM_REQ-1:0] r_grant;
   logic [SW-1:0]      r_stall;
   logic [GW-1:0]      r_gap;
   logic               r_timeout_err;
   logic               w_in_xfer;
   logic               w_g_valid;
   logic               w_g_last;
   logic [7:0]         w_g_data;
   logic               w_beat;
   logic               w_timeout;
   logic               w_done;

   assign w_in_xfer = (r_state == S_XFER);
   assign w_g_valid = src_valid[r_gidx];
   assign w_g_last  = src_last[r_gidx];
   assign w_g_data  = src_data[{r_gidx, 3'b000} +: 8];
   assign w_beat    = w_in_xfer & w_g_valid & tx_ready;
   // Abort on the clock that would take the stall count to TIMEOUT_CYCLES.
   assign w_timeout = w_in_xfer & ~w_g_valid & (r_stall == STALL_MAX);
   assign w_done    = (w_beat & w_g_last) | w_timeout;

   assign grant       = r_grant;
   assign busy        = (r_state != S_IDLE);
   assign timeout_err = r_timeout_err;

   // First valid requester at or after r_ptr, wrapping.
   always_comb begin : arb
      int j;
      w_win_vld = 1'b0;
      w_win_idx = r_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(r_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!w_win_vld && src_valid[j]) begin
            w_win_vld = 1'b1;
            w_win_idx = IW'(j);
         end
      end
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      src_ready   = '0;
      tx_valid    = 1'b0;
      tx_data     = '0;
      case (r_state)
         S_IDLE:  if (w_win_vld) w_state_nxt = S_XFER;
         S_XFER: begin
            tx_valid          = w_g_valid;
            tx_data           = w_g_data;
            src_ready[r_gidx] = tx_ready;
            if (w_done) w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         end
         S_GAP:   if (r_gap == GAP_MAX) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         r_grant       <= '0;
         r_gidx        <= '0;
         r_ptr         <= '0;
         r_stall       <= '0;
         r_gap         <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout;
         case (r_state)
            S_IDLE: begin
               // Pointer moves at grant time, so an aborted owner is skipped next round too.
               if (w_win_vld) begin
                  r_grant <= NUM_REQ'(1) << w_win_idx;
                  r_gidx  <= w_win_idx;
                  r_ptr   <= (w_win_idx == LAST_IDX) ? '0 : w_win_idx + 1'b1;
                  r_stall <= '0;
               end
            end
            S_XFER: begin
               if (w_g_valid) r_stall <= '0;
               else           r_stall <= r_stall + 1'b1;
               if (w_done) begin
                  r_grant <= '0;
                  r_gap   <= '0;
               end
            end
            S_GAP:   r_gap <= r_gap + 1'b1;
            default: r_gap <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-source packet queues drive the DUT; a transaction-level
// owner/gap/pointer model predicts every output each cycle. A GAP_CYCLES=0 instance shares the inputs.
module tb_uart_tx_arbiter;
   localparam int N   = 4;
   localparam int GAP = 16;
   localparam int TO  = 10;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   src_valid, src_last;
   logic [8*N-1:0] src_data;
   logic           tx_ready;
   logic [N-1:0]   src_ready, grant, src_ready1, grant1;
   logic [7:0]     tx_data, tx_data1;
   logic           tx_valid, busy, timeout_err, tx_valid1, busy1, timeout_err1;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk_100MHz(clk), .reset_n(reset_n), .src_valid(src_valid), .src_data(src_data),
      .src_last(src_last), .src_ready(src_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .grant(grant), .busy(busy), .timeout_err(timeout_err));

   uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) u_dut_nogap (
      .clk_100MHz(clk), .reset_n(reset_n), .src_valid(src_valid), .src_data(src_data),
      .src_last(src_last), .src_ready(src_ready1), .tx_data(tx_data1), .tx_valid(tx_valid1),
      .tx_ready(tx_ready), .grant(grant1), .busy(busy1), .timeout_err(timeout_err1));

   int          n_checks, n_fail;
   logic [8:0]  q_src [N][$];      // {last, data}
   int          vprob, rprob;
   int          m_owner, m_gap, m_ptr, m_stall;
   bit          m_pulse;
   int          cyc, n_to, n_gap, zero_run;
   bit          seen_grant;
   logic [N-1:0] prev_grant;
   logic [7:0]  tx_log[$];
   logic [N-1:0] g_log[$];
   int          z_log[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += q_src[i].size();
      return s;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_gap = 0; m_ptr = 0; m_stall = 0; m_pulse = 0;
   endtask

   task automatic clear_logs();
      tx_log.delete(); g_log.delete(); z_log.delete();
      n_to = 0; n_gap = 0; zero_run = 0; seen_grant = 0; prev_grant = '0;
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_grant"}, grant, 0);
      check_eq({tag, "_src_ready"}, src_ready, 0);
      check_eq({tag, "_tx_valid"}, tx_valid, 0);
      check_eq({tag, "_tx_data"}, tx_data, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_timeout_err"}, timeout_err, 0);
      check_eq({tag, "_ng_outs"}, {grant1, src_ready1, tx_data1, tx_valid1, busy1, timeout_err1}, 0);
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         logic [8:0] e;
         e = (q_src[i].size() > 0) ? q_src[i][0] : 9'h000;
         src_valid[i]       = (q_src[i].size() > 0) && (int'($urandom_range(99)) < vprob);
         src_data[i*8 +: 8] = e[7:0];
         src_last[i]        = e[8];
      end
      tx_ready = (int'($urandom_range(99)) < rprob);
   endtask

   task automatic compare_outputs();
      logic [N-1:0] eg, er;
      logic         ev;
      logic [7:0]   ed;
      eg = '0; er = '0; ev = 1'b0; ed = '0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         er[m_owner] = tx_ready;
         ev          = src_valid[m_owner];
         ed          = src_data[m_owner*8 +: 8];
      end
      check_eq("grant", grant, eg);
      check_eq("src_ready", src_ready, er);
      check_eq("tx_valid", tx_valid, ev);
      check_eq("tx_data", tx_data, ed);
      check_eq("busy", busy, (m_owner >= 0) || (m_gap > 0));
      check_eq("timeout_err", timeout_err, m_pulse);
   endtask

   // Packet-level rules: owner holds until its last byte moves or it stalls TO clocks,
   // then GAP idle clocks, then round-robin pick among currently valid sources.
   task automatic model_step();
      bit pulse;
      pulse = 0;
      if (m_owner >= 0) begin
         bit v;
         v = src_valid[m_owner];
         m_stall = v ? 0 : m_stall + 1;
         if ((v && tx_ready && src_last[m_owner]) || m_stall == TO) begin
            pulse   = (m_stall == TO);
            m_owner = -1;
            m_gap   = GAP;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else begin
         for (int k = 0; k < N; k++)
            if (m_owner < 0 && src_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
         if (m_owner >= 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_stall = 0;
         end
      end
      m_pulse = pulse;
   endtask

   // Entered and left at posedge+1.
   task automatic cycle();
      drive_inputs();
      @(negedge clk);
      compare_outputs();
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (timeout_err) n_to++;
      if (busy && grant == '0) n_gap++;
      if (grant != '0 && prev_grant == '0) begin
         g_log.push_back(grant);
         if (seen_grant) z_log.push_back(zero_run);
         seen_grant = 1;
      end
      zero_run   = (grant == '0) ? zero_run + 1 : 0;
      prev_grant = grant;
      for (int i = 0; i < N; i++)
         if (src_valid[i] && src_ready[i]) void'(q_src[i].pop_front());
      model_step();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) q_src[i].delete();
      src_valid = '0; src_data = '0; src_last = '0; tx_ready = 1'b0;
      #1 check_reset("rst");
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;
      model_reset();
      clear_logs();
   endtask

   task automatic run_until_txn(input int n, input int budget, input string tag);
      int c = 0;
      while (tx_log.size() < n && c < budget) begin
         cycle();
         c++;
      end
      check_eq({tag, "_bytes_reached"}, tx_log.size() >= n, 1);
   endtask

   task automatic run_until_idle(input int budget, input string tag);
      int c = 0;
      do begin
         cycle();
         c++;
      end while ((busy || pending() != 0) && c < budget);
      check_eq({tag, "_idle"}, {busy, pending() != 0}, 0);
   endtask

   initial begin
      logic [7:0] exp1 [3];
      int t_x, t_to, c, unstable;
      exp1 = '{8'h41, 8'h42, 8'h43};
      n_checks = 0; n_fail = 0; cyc = 0; vprob = 100; rprob = 100;
      reset_n = 1'b0; src_valid = '0; src_data = '0; src_last = '0; tx_ready = 1'b0;
      model_reset(); clear_logs();
      @(posedge clk); #1;
      do_reset();

      // Src1 three-byte packet.
      q_src[1].push_back(9'h041); q_src[1].push_back(9'h042); q_src[1].push_back(9'h143);
      cycle();
      check_eq("t1_grant_after_1clk", grant, 4'b0010);
      run_until_idle(60, "t1");
      check_eq("t1_nbytes", tx_log.size(), 3);
      for (int i = 0; i < 3 && i < tx_log.size(); i++) check_eq("t1_byte", tx_log[i], exp1[i]);
      check_eq("t1_gap_len", n_gap, GAP);

      // All four sources contend with one-byte packets.
      do_reset();
      for (int i = 0; i < N; i++) q_src[i].push_back({1'b1, 8'h10 + 8'(i)});
      run_until_idle(200, "t2");
      check_eq("t2_ngrants", g_log.size(), 4);
      for (int i = 0; i < 4 && i < g_log.size(); i++) check_eq("t2_order", g_log[i], 4'b0001 << i);
      // GAP clocks plus the one IDLE arbitration clock between owners.
      for (int i = 0; i < z_log.size(); i++) check_eq("t2_separation", z_log[i], GAP + 1);
      check_eq("t2_gap_total", n_gap, 4 * GAP);

      // Backpressure mid-packet never times out.
      do_reset();
      for (int i = 0; i < 4; i++) q_src[2].push_back({(i == 3) ? 1'b1 : 1'b0, 8'hB0 + 8'(i)});
      run_until_txn(1, 20, "t3_first");
      rprob = 0; unstable = 0;
      repeat (50) begin
         cycle();
         if (tx_data !== 8'hB1 || tx_valid !== 1'b1) unstable++;
      end
      check_eq("t3_byte_held", unstable, 0);
      check_eq("t3_stall_no_xfer", tx_log.size(), 1);
      rprob = 100;
      run_until_idle(60, "t3");
      check_eq("t3_nbytes", tx_log.size(), 4);
      check_eq("t3_no_timeout", n_to, 0);

      // Src0 stops mid-packet: abort after TO stalled clocks.
      do_reset();
      q_src[0].push_back(9'h0C0);
      run_until_txn(1, 20, "t4_byte");
      t_x = cyc - 1; t_to = -1; c = 0;
      while (n_to == 0 && c < 40) begin
         cycle();
         c++;
         if (n_to != 0) t_to = cyc - 1;
      end
      check_eq("t4_timeout_delay", t_to - t_x, TO + 1);
      repeat (5) cycle();
      check_eq("t4_single_pulse", n_to, 1);
      q_src[1].push_back(9'h1D0);
      c = 0;
      while (grant == '0 && c < 40) begin
         cycle();
         c++;
      end
      check_eq("t4_next_grant", grant, 4'b0010);
      run_until_idle(60, "t4");

      // Asynchronous reset during byte 2 of a 4-byte packet.
      do_reset();
      for (int i = 0; i < 4; i++) q_src[0].push_back({(i == 3) ? 1'b1 : 1'b0, 8'hE0 + 8'(i)});
      run_until_txn(1, 20, "t5_byte1");
      drive_inputs();
      #2 reset_n = 1'b0;
      #1 check_reset("t5_async");
      for (int i = 0; i < N; i++) q_src[i].delete();
      src_valid = '0; src_last = '0; src_data = '0;
      repeat (2) begin
         @(negedge clk);
         check_reset("t5_held");
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      model_reset(); clear_logs();
      q_src[3].push_back(9'h1F3);
      cycle();
      check_eq("t5_fresh_grant", grant, 4'b1000);
      run_until_idle(60, "t5");

      // GAP_CYCLES=0 instance: back-to-back one-byte packets from src0.
      do_reset();
      for (int i = 0; i < 4; i++) q_src[0].push_back({1'b1, 8'hA0 + 8'(i)});
      for (int k = 0; k < 8; k++) begin
         cycle();
         check_eq("t6_ng_grant", grant1, (k % 2 == 0) ? 4'b0001 : 4'b0000);
         check_eq("t6_ng_busy", busy1, (k % 2 == 0) ? 1 : 0);
         check_eq("t6_ng_tx_valid", tx_valid1, (k % 2 == 0) ? 1 : 0);
      end
      run_until_idle(200, "t6");

      // Random contention with random valid/ready.
      do_reset();
      vprob = 70; rprob = 70;
      for (int i = 0; i < N; i++)
         for (int p = 0; p < 6; p++) begin
            int len;
            len = int'($urandom_range(4, 1));
            for (int b = 0; b < len; b++)
               q_src[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
         end
      run_until_idle(3000, "t7");
      check_eq("t7_drained", pending(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
